// File: rtl/beam_scan_controller.sv
// Beam select sequencer: manual or automatic sweep of the tap-pattern select, with output blanking while the delay line settles.
// Optional BEAM_SCAN_PINGPONG_EN makes the sweep bounce between sel_lo and sel_hi instead of wrapping.
module beam_scan_controller #(
  parameter int SEL_W         = 4,
  parameter int DWELL_CYCLES  = 50000000,
  parameter int SETTLE_CYCLES = 8501,
  parameter int CNT_W         = 26,
  parameter int RESET_SEL     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sweep_en,
  input  logic [SEL_W-1:0] manual_sel,
  input  logic [SEL_W-1:0] sel_lo,
  input  logic [SEL_W-1:0] sel_hi,
  output logic [SEL_W-1:0] sel,
  output logic             blank,
  output logic             settled,
  output logic             step_pulse,
  output logic             sweep_wrap
);

  typedef enum logic {SETTLE, DWELL} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_RST     = SEL_W'(RESET_SEL);
  localparam logic [SEL_W-1:0] SEL_ONE     = SEL_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [SEL_W-1:0] sel_nx, step_sel;
  logic             blank_nx, step_nx, wrap_nx, step_wrap;
  logic             sweep_q, manual_req;

`ifdef BEAM_SCAN_PINGPONG_EN
  logic dir, dir_nx, step_dir;  // 0 = up, 1 = down

  always_comb begin
    step_sel  = sel_lo;
    step_wrap = 1'b0;
    step_dir  = dir;
    if (sel_lo > sel_hi || sel < sel_lo || sel > sel_hi) begin
      step_dir = 1'b0;
    end else if (sel_lo == sel_hi) begin
      step_sel  = sel;
      step_wrap = 1'b1;
    end else if (!dir) begin
      if (sel < sel_hi) step_sel = sel + SEL_ONE;
      else begin
        step_sel  = sel - SEL_ONE;
        step_dir  = 1'b1;
        step_wrap = 1'b1;
      end
    end else begin
      if (sel > sel_lo) step_sel = sel - SEL_ONE;
      else begin
        step_sel  = sel + SEL_ONE;
        step_dir  = 1'b0;
        step_wrap = 1'b1;
      end
    end
  end
`else
  always_comb begin
    step_sel  = sel_lo;
    step_wrap = 1'b0;
    // An inverted range just parks at sel_lo; it never counts as a completed pass.
    if (sel_lo <= sel_hi) begin
      if (sel >= sel_lo && sel < sel_hi) step_sel = sel + SEL_ONE;
      else                               step_wrap = (sel == sel_hi);
    end
  end
`endif

  assign manual_req = !sweep_en && (manual_sel != sel);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = sel;
    blank_nx = blank;
    step_nx  = 1'b0;
    wrap_nx  = 1'b0;
`ifdef BEAM_SCAN_PINGPONG_EN
    dir_nx   = dir;
`endif
    case (state)
      SETTLE: begin
        if (manual_req) begin
          sel_nx  = manual_sel;
          step_nx = 1'b1;
          cnt_nx  = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_nx = DWELL;
          cnt_nx   = '0;
          blank_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        if (!sweep_en) begin
          cnt_nx = '0;
          if (manual_req) begin
            sel_nx   = manual_sel;
            step_nx  = 1'b1;
            blank_nx = 1'b1;
            state_nx = SETTLE;
          end
        end else if (!sweep_q) begin
          cnt_nx = '0;  // sweep just enabled: dwell restarts
        end else if (cnt == DWELL_LAST) begin
          cnt_nx = '0;
`ifdef BEAM_SCAN_PINGPONG_EN
          dir_nx = step_dir;
`endif
          if (step_sel != sel) begin
            sel_nx   = step_sel;
            step_nx  = 1'b1;
            blank_nx = 1'b1;
            wrap_nx  = step_wrap;
            state_nx = SETTLE;
          end else if (sel_lo == sel_hi) begin
            // Single-angle range: report the step and pass without re-settling.
            step_nx = 1'b1;
            wrap_nx = step_wrap;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SETTLE;
      cnt        <= '0;
      sel        <= SEL_RST;
      blank      <= 1'b1;
      settled    <= 1'b0;
      step_pulse <= 1'b0;
      sweep_wrap <= 1'b0;
      sweep_q    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sel        <= sel_nx;
      blank      <= blank_nx;
      settled    <= ~blank_nx;
      step_pulse <= step_nx;
      sweep_wrap <= wrap_nx;
      sweep_q    <= sweep_en;
    end
  end

`ifdef BEAM_SCAN_PINGPONG_EN
  always_ff @(posedge clk) begin
    if (rst) dir <= 1'b0;
    else     dir <= dir_nx;
  end
`endif

endmodule

// File: tb/tb_beam_scan_controller.sv
// Self-checking bench for beam_scan_controller: directed scenarios plus random stimulus against a countdown-style reference model.
module tb_beam_scan_controller;
  localparam int DWELL  = 10;
  localparam int SETTLE = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sweep_en = 1'b0;
  logic [3:0] manual_sel = 4'd7, sel_lo = 4'd0, sel_hi = 4'd15;
  logic [3:0] sel;
  logic       blank, settled, step_pulse, sweep_wrap;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  beam_scan_controller #(
    .SEL_W(4), .DWELL_CYCLES(DWELL), .SETTLE_CYCLES(SETTLE), .CNT_W(26), .RESET_SEL(7)
  ) dut (
    .clk(clk), .rst(rst), .sweep_en(sweep_en), .manual_sel(manual_sel),
    .sel_lo(sel_lo), .sel_hi(sel_hi), .sel(sel), .blank(blank), .settled(settled),
    .step_pulse(step_pulse), .sweep_wrap(sweep_wrap)
  );

  // Reference model: blanking tracked as cycles-left, dwell as cycles-elapsed.
  typedef struct packed {
    logic [3:0] sel;
    logic       blank, step, wrap, prev_sw, dir;
    int         left;
    int         dwell;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(mstate_t s, logic r, logic sw,
                                         logic [3:0] man, logic [3:0] lo, logic [3:0] hi);
    mstate_t n;
    logic [3:0] tgt;
    logic w;
    int ilo, ihi, isel;
    n = s; n.step = 1'b0; n.wrap = 1'b0; n.prev_sw = sw;
    if (r) begin
      n.sel = 4'd7; n.blank = 1'b1; n.left = SETTLE; n.dwell = 0; n.prev_sw = 1'b0; n.dir = 1'b0;
      return n;
    end
    if (!sw && man != s.sel) begin
      n.sel = man; n.step = 1'b1; n.blank = 1'b1; n.left = SETTLE;
      return n;
    end
    if (s.blank) begin
      n.left = s.left - 1;
      if (n.left == 0) begin n.blank = 1'b0; n.dwell = 0; end
      return n;
    end
    if (!sw || !s.prev_sw) begin n.dwell = 0; return n; end
    n.dwell = s.dwell + 1;
    if (n.dwell < DWELL) return n;
    n.dwell = 0;
    ilo = int'(lo); ihi = int'(hi); isel = int'(s.sel);
    tgt = lo; w = 1'b0;
`ifdef BEAM_SCAN_PINGPONG_EN
    if (ilo > ihi || isel < ilo || isel > ihi) n.dir = 1'b0;
    else if (ilo == ihi) begin tgt = s.sel; w = 1'b1; end
    else if (!s.dir) begin
      if (isel < ihi) tgt = 4'(isel + 1);
      else begin tgt = 4'(isel - 1); n.dir = 1'b1; w = 1'b1; end
    end else begin
      if (isel > ilo) tgt = 4'(isel - 1);
      else begin tgt = 4'(isel + 1); n.dir = 1'b0; w = 1'b1; end
    end
`else
    if (ilo <= ihi) begin
      if (isel >= ilo && isel < ihi) tgt = 4'(isel + 1);
      else w = (isel == ihi);
    end
`endif
    if (tgt != s.sel) begin
      n.sel = tgt; n.step = 1'b1; n.blank = 1'b1; n.left = SETTLE; n.wrap = w;
    end else if (ilo == ihi) begin
      n.step = 1'b1; n.wrap = w;
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m, rst, sweep_en, manual_sel, sel_lo, sel_hi);

  logic [7:0] dut_v, mod_v;
  assign dut_v = {sel, blank, settled, step_pulse, sweep_wrap};
  assign mod_v = {m.sel, m.blank, ~m.blank, m.step, m.wrap};

  task automatic wait_settled();
    int n = 0;
    @(negedge clk);
    while (!settled && n < 60) begin @(negedge clk); n++; end
    if (!settled) begin
      checks++; errors++;
      $display("FAIL settle_timeout: settled=%b after %0d cycles, required 1", settled, n);
    end
  endtask

  task automatic test_reset();
    int nblank = 0;
    rst = 1'b1; sweep_en = 1'b0; manual_sel = 4'd7; sel_lo = 4'd0; sel_hi = 4'd15;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sel, blank, settled, step_pulse, sweep_wrap} !== {4'd7, 4'b1000}) begin
      errors++; $display("FAIL reset_values: got %h required %h", dut_v, {4'd7, 4'b1000});
    end
    rst = 1'b0;
    nblank += blank;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      nblank += blank;
      checks++;
      if (dut_v !== mod_v || step_pulse) begin
        errors++; $display("FAIL reset cyc %0d: got %h required %h", i, dut_v, mod_v);
      end
    end
    checks++;
    if (nblank != SETTLE) begin
      errors++; $display("FAIL reset_blank_len: got %0d required %0d", nblank, SETTLE);
    end
  endtask

  task automatic test_manual();
    int nblank = 0;
    manual_sel = 4'd12;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== mod_v) begin
        errors++; $display("FAIL manual cyc %0d: got %h required %h", i, dut_v, mod_v);
      end
      if (i == 1) begin
        checks++;
        if ({sel, step_pulse, blank} !== {4'd12, 2'b11}) begin
          errors++; $display("FAIL manual_first: sel=%0d step=%b blank=%b required 12 1 1", sel, step_pulse, blank);
        end
      end
      if (i >= 3) nblank += blank;
      if (i == 2) manual_sel = 4'd3;
    end
    checks++;
    if (nblank != SETTLE || sel !== 4'd3) begin
      errors++; $display("FAIL manual_retrigger: blank_len=%0d sel=%0d required %0d 3", nblank, sel, SETTLE);
    end
  endtask

  task automatic test_sweep_wrap();
    logic [3:0] seq[$];
    int         when[$];
    logic       wr[$];
    logic [3:0] exp_seq [4] = '{4'd5, 4'd6, 4'd7, 4'd5};
    logic [3:0] prev;
    manual_sel = 4'd7;
    wait_settled();
    sel_lo = 4'd5; sel_hi = 4'd7; sweep_en = 1'b1;
    prev = sel;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== mod_v) begin
        errors++; $display("FAIL sweep cyc %0d: got %h required %h", i, dut_v, mod_v);
      end
      if (step_pulse) begin
        seq.push_back(sel); when.push_back(i); wr.push_back(sweep_wrap);
        checks++;
        if (sweep_wrap !== (prev == 4'd7)) begin
          errors++; $display("FAIL sweep_wrap_pos: %0d->%0d wrap=%b", prev, sel, sweep_wrap);
        end
        prev = sel;
      end
    end
    checks++;
    if (seq.size() != 4) begin
      errors++; $display("FAIL sweep_count: got %0d steps required 4", seq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (seq[k] !== exp_seq[k] || (k > 0 && when[k] - when[k-1] != DWELL + SETTLE)) begin
          errors++; $display("FAIL sweep_seq %0d: sel=%0d at %0d required %0d", k, seq[k], when[k], exp_seq[k]);
        end
      end
    end
  endtask

  task automatic test_invalid_range();
    int nstep = 0, nwrap = 0;
    sweep_en = 1'b0; manual_sel = 4'd2;
    wait_settled();
    sel_lo = 4'd9; sel_hi = 4'd4; sweep_en = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      nstep += step_pulse; nwrap += sweep_wrap;
      checks++;
      if (dut_v !== mod_v) begin
        errors++; $display("FAIL invalid cyc %0d: got %h required %h", i, dut_v, mod_v);
      end
    end
    checks++;
    if (nstep != 1 || nwrap != 0 || sel !== 4'd9) begin
      errors++; $display("FAIL invalid_hold: steps=%0d wraps=%0d sel=%0d required 1 0 9", nstep, nwrap, sel);
    end
  endtask

  task automatic test_single_angle();
    int nstep = 0, nwrap = 0, nblank = 0;
    sweep_en = 1'b0; manual_sel = 4'd5;
    wait_settled();
    sel_lo = 4'd5; sel_hi = 4'd5; sweep_en = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      nstep += step_pulse; nwrap += sweep_wrap; nblank += blank;
      checks++;
      if (dut_v !== mod_v) begin
        errors++; $display("FAIL single cyc %0d: got %h required %h", i, dut_v, mod_v);
      end
    end
    checks++;
    if (nstep != 4 || nwrap != 4 || nblank != 0 || sel !== 4'd5) begin
      errors++; $display("FAIL single_angle: steps=%0d wraps=%0d blank=%0d sel=%0d required 4 4 0 5", nstep, nwrap, nblank, sel);
    end
  endtask

  task automatic test_reset_mid_settle();
    int nblank = 0;
    sweep_en = 1'b0; manual_sel = 4'd10;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== mod_v) begin
        errors++; $display("FAIL midrst cyc %0d: got %h required %h", i, dut_v, mod_v);
      end
    end
    rst = 1'b1; manual_sel = 4'd7;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({sel, blank, step_pulse} !== {4'd7, 2'b10}) begin
      errors++; $display("FAIL midrst_values: sel=%0d blank=%b step=%b required 7 1 0", sel, blank, step_pulse);
    end
    nblank += blank;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      nblank += blank;
      checks++;
      if (dut_v !== mod_v) begin
        errors++; $display("FAIL midrst_after cyc %0d: got %h required %h", i, dut_v, mod_v);
      end
    end
    checks++;
    if (nblank != SETTLE) begin
      errors++; $display("FAIL midrst_blank_len: got %0d required %0d", nblank, SETTLE);
    end
  endtask

`ifdef BEAM_SCAN_PINGPONG_EN
  task automatic test_pingpong();
    logic [3:0] exp_seq [7] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1};
    logic       exp_wr  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int k = 0;
    rst = 1'b1; sweep_en = 1'b0; manual_sel = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    wait_settled();
    sel_lo = 4'd0; sel_hi = 4'd3; sweep_en = 1'b1;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== mod_v) begin
        errors++; $display("FAIL pingpong cyc %0d: got %h required %h", i, dut_v, mod_v);
      end
      if (step_pulse && k < 7) begin
        checks++;
        if (sel !== exp_seq[k] || sweep_wrap !== exp_wr[k]) begin
          errors++; $display("FAIL pingpong_seq %0d: sel=%0d wrap=%b required %0d %b", k, sel, sweep_wrap, exp_seq[k], exp_wr[k]);
        end
        k++;
      end
    end
    checks++;
    if (k != 7) begin
      errors++; $display("FAIL pingpong_count: got %0d steps required 7", k);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== mod_v) begin
        errors++; $display("FAIL random cyc %0d: got %h required %h", i, dut_v, mod_v);
      end
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) sweep_en = ~sweep_en;
      if ($urandom_range(0, 24) == 0) manual_sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) begin
        sel_lo = 4'($urandom_range(0, 15));
        sel_hi = ($urandom_range(0, 4) == 0) ? sel_lo : 4'($urandom_range(0, 15));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_sweep_wrap();
    test_invalid_range();
    test_single_angle();
    test_reset_mid_settle();
`ifdef BEAM_SCAN_PINGPONG_EN
    test_pingpong();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
